uart_adder_ctrl: RTL and testbench
==================================

Name: uart_adder_ctrl

Overview:
Sequencer for the 64-bit ripple-carry adder in the UART adder path. Collects two little-endian operands byte-by-byte from the UART receiver and drives them onto the adder. Waits a fixed settle time, captures sum and carry, then streams the result to the UART transmitter under a valid/ready handshake. Sits between uart_rx/uart_tx and ripple_carry_adder_64bit.

Parameters:
OP_BYTES, 8, bytes per operand; operand width = 8*OP_BYTES (must be 8 for the 64-bit adder).
ADD_LATENCY, 4, cycles operands are held stable before sum/carry are captured (ripple settle budget, >=1).
TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
clk_i  input  1  system clock, all logic on rising edge.
rst_i  input  1  synchronous, active-high reset.
rx_data_i  input  8  received byte.
rx_valid_i  input  1  one-cycle strobe, rx_data_i valid.
tx_data_o  output  8  byte to transmit.
tx_valid_o  output  1  tx_data_o valid; held until accepted.
tx_ready_i  input  1  transmitter can accept a byte.
add_a_o  output  64  operand A to adder.
add_b_o  output  64  operand B to adder.
add_cin_o  output  1  adder carry-in, constant 0.
add_s_i  input  64  adder sum.
add_cout_i  input  1  adder carry-out.
busy_o  output  1  high in ADD, TX_SUM and TX_CARRY.
overrun_o  output  1  one-cycle pulse when an rx byte is dropped.

Behaviour:
- Reset (rst_i=1 at clock edge): state RX_A, byte counter 0; add_a_o, add_b_o, result register and tx_data_o cleared to 0; tx_valid_o=0, busy_o=0, overrun_o=0, add_cin_o=0. Reset overrides everything, including mid-transfer; a partially sent result is abandoned, never resumed.
- RX_A: each rx_valid_i writes rx_data_i into add_a_o byte [cnt] (first byte = bits 7:0). cnt increments; on byte OP_BYTES-1, cnt->0 and state->RX_B.
- RX_B: same as RX_A into add_b_o. On the last byte -> ADD, latency counter loaded with ADD_LATENCY-1.
- ADD: operands are held constant. Counter decrements each cycle. At 0: capture add_s_i and add_cout_i into the result register, then -> TX_SUM, cnt=0.
- TX_SUM: tx_valid_o=1, tx_data_o = result byte [cnt], LSB first. A byte is transferred on a cycle with tx_valid_o & tx_ready_i. cnt then increments and the next byte appears the following cycle with no valid gap. After byte OP_BYTES-1 is transferred -> TX_CARRY.
- TX_CARRY: tx_data_o = {7'b0, carry}; on transfer, tx_valid_o drops in the same edge's registered update and state -> RX_A, cnt=0. Operands keep their last values until overwritten.
- tx_data_o must not change while tx_valid_o=1 && tx_ready_i=0.
- rx_valid_i outside RX_A/RX_B: byte dropped, overrun_o pulses 1 cycle; state is unaffected.
- Total response: exactly OP_BYTES+1 tx bytes per operand pair. Capture occurs exactly ADD_LATENCY cycles after the edge that accepted B's last byte.
- All arithmetic is modulo 2^64; the overflow is reported only through the carry byte.

Optional Feature:
INTERBYTE_TIMEOUT_EN: when defined, a counter runs in RX_A/RX_B whenever cnt!=0 or state==RX_B. It clears on each rx_valid_i. On reaching TIMEOUT_CYCLES, state->RX_A, cnt=0, operands cleared, and overrun_o pulses 1 cycle. When undefined, there is no timeout logic, and partial frames wait indefinitely.

Test Plan:
- A=20, B=20, tx_ready_i=1 -> tx bytes 0x28, then 0x00 x7, then carry byte 0x00; tx_valid_o high for 9 consecutive cycles.
- A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> sum bytes 0x00 x8, carry byte 0x01.
- A=9999, B=1, tx_ready_i toggled 1/0 every cycle -> bytes 0x10, 0x27, 0x00 x6, 0x00, each held stable while ready=0; no byte is lost or duplicated.
- rx_valid_i pulse during TX_SUM -> overrun_o 1-cycle pulse; the output stream is unchanged; the next frame is received correctly.
- rst_i asserted after 3 of 8 sum bytes are sent -> next cycle tx_valid_o=0 and outputs are zero. A fresh A=1, B=1 then yields 0x02, 0x00 x7, 0x00.
- With INTERBYTE_TIMEOUT_EN and TIMEOUT_CYCLES=50: send 3 bytes then idle 50 cycles -> overrun_o pulse, return to RX_A; next full frame A=1000, B=1000 -> 0xD0, 0x07, 0x00 x6, 0x00.

Source files
------------

// File: rtl/uart_adder_ctrl.sv
// ---------------------------------------------------------------------------
// uart_adder_ctrl
//
// Sequencer for the 64-bit ripple-carry adder in the UART adder path.
// It collects operand A and then operand B from the UART receiver, one byte
// at a time, least significant byte first. Both operands are held on the
// adder while the ripple settles, then sum and carry are captured. The
// result goes to the UART transmitter as OP_BYTES sum bytes, LSB first,
// followed by one carry byte {7'b0, carry}.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous, active-high reset
//   rx_data_i    received byte
//   rx_valid_i   one-cycle strobe qualifying rx_data_i
//   tx_data_o    byte to transmit (registered)
//   tx_valid_o   tx_data_o valid (registered)
//   tx_ready_i   transmitter can accept a byte
//   add_a_o      operand A to the adder
//   add_b_o      operand B to the adder
//   add_cin_o    adder carry-in, tied to 0
//   add_s_i      adder sum
//   add_cout_i   adder carry-out
//   busy_o       high in ADD, TX_SUM and TX_CARRY
//   overrun_o    one-cycle pulse when an rx byte is dropped (or a frame
//                times out, see below)
//   dbg_state_o  current FSM state: 0 RX_A, 1 RX_B, 2 ADD, 3 TX_SUM,
//                4 TX_CARRY
//
// Handshake: a byte moves on every rising edge where tx_valid_o and
// tx_ready_i are both high. Once tx_valid_o is raised it stays high and
// tx_data_o stays constant until that transfer. The next byte appears in
// the cycle after the transfer, with no valid gap inside a response. The
// rx side has no back-pressure: rx_valid_i strobes that arrive outside
// RX_A/RX_B are dropped and flagged on overrun_o.
//
// Optional build macro INTERBYTE_TIMEOUT_EN: a partially received frame is
// abandoned after TIMEOUT_CYCLES idle cycles. The FSM returns to RX_A, the
// operands are cleared and overrun_o pulses. Without the macro, a partial
// frame waits indefinitely.
// ---------------------------------------------------------------------------
module uart_adder_ctrl #(
  parameter int OP_BYTES       = 8,
  parameter int ADD_LATENCY    = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [8*OP_BYTES-1:0] add_a_o,
  output logic [8*OP_BYTES-1:0] add_b_o,
  output logic                  add_cin_o,
  input  logic [8*OP_BYTES-1:0] add_s_i,
  input  logic                  add_cout_i,
  output logic                  busy_o,
  output logic                  overrun_o,
  output logic [2:0]            dbg_state_o
);

  localparam int W     = 8 * OP_BYTES;
  localparam int CNT_W = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
  localparam int LAT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OP_BYTES - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ADD_LATENCY - 1);

  typedef enum logic [2:0] {
    RX_A     = 3'd0,
    RX_B     = 3'd1,
    ADD      = 3'd2,
    TX_SUM   = 3'd3,
    TX_CARRY = 3'd4
  } state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic [LAT_W-1:0] lat_q, lat_n;
  logic [W-1:0]     a_q, a_n;
  logic [W-1:0]     b_q, b_n;
  logic [W:0]       res_q, res_n;      // {carry, sum}
  logic [7:0]       tx_data_q, tx_data_n;
  logic             tx_valid_q, tx_valid_n;
  logic             overrun_q, overrun_n;
  logic             tx_fire;
  logic             rx_window;

`ifdef INTERBYTE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_q, to_n;
  logic            to_run;
`endif

  assign cnt_inc   = cnt_q + 1'b1;
  assign tx_fire   = tx_valid_q & tx_ready_i;
  assign rx_window = (state_q == RX_A) || (state_q == RX_B);

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    lat_n      = lat_q;
    a_n        = a_q;
    b_n        = b_q;
    res_n      = res_q;
    tx_data_n  = tx_data_q;
    tx_valid_n = tx_valid_q;
    overrun_n  = 1'b0;
`ifdef INTERBYTE_TIMEOUT_EN
    to_n       = '0;
    to_run     = 1'b0;
`endif

    case (state_q)
      RX_A: begin
        if (rx_valid_i) begin
          for (int i = 0; i < OP_BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) a_n[i*8 +: 8] = rx_data_i;
          end
          if (cnt_q == LAST_IDX) begin
            cnt_n   = '0;
            state_n = RX_B;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end

      RX_B: begin
        if (rx_valid_i) begin
          for (int i = 0; i < OP_BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) b_n[i*8 +: 8] = rx_data_i;
          end
          if (cnt_q == LAST_IDX) begin
            cnt_n   = '0;
            lat_n   = LAT_LOAD;
            state_n = ADD;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end

      ADD: begin
        // The counter is loaded with ADD_LATENCY-1 on the accepting edge.
        // Capture therefore lands ADD_LATENCY edges later. The first sum
        // byte is presented on that same edge.
        if (lat_q == '0) begin
          res_n      = {add_cout_i, add_s_i};
          cnt_n      = '0;
          tx_valid_n = 1'b1;
          tx_data_n  = add_s_i[7:0];
          state_n    = TX_SUM;
        end else begin
          lat_n = lat_q - 1'b1;
        end
      end

      TX_SUM: begin
        if (tx_fire) begin
          if (cnt_q == LAST_IDX) begin
            cnt_n     = '0;
            tx_data_n = {7'b0, res_q[W]};
            state_n   = TX_CARRY;
          end else begin
            cnt_n = cnt_inc;
            for (int i = 0; i < OP_BYTES; i++) begin
              if (cnt_inc == CNT_W'(i)) tx_data_n = res_q[i*8 +: 8];
            end
          end
        end
      end

      TX_CARRY: begin
        if (tx_fire) begin
          tx_valid_n = 1'b0;
          cnt_n      = '0;
          state_n    = RX_A;
        end
      end

      default: begin
        state_n    = RX_A;
        cnt_n      = '0;
        tx_valid_n = 1'b0;
      end
    endcase

    if (rx_valid_i && !rx_window) overrun_n = 1'b1;

`ifdef INTERBYTE_TIMEOUT_EN
    // Idle counter for a frame in progress. Any received byte restarts it.
    to_run = ((state_q == RX_A) && (cnt_q != '0)) || (state_q == RX_B);
    if (to_run && !rx_valid_i) begin
      if (to_q == TO_LAST) begin
        state_n   = RX_A;
        cnt_n     = '0;
        a_n       = '0;
        b_n       = '0;
        overrun_n = 1'b1;
        to_n      = '0;
      end else begin
        to_n = to_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RX_A;
      cnt_q      <= '0;
      lat_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef INTERBYTE_TIMEOUT_EN
      to_q       <= '0;
`endif
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      lat_q      <= lat_n;
      a_q        <= a_n;
      b_q        <= b_n;
      res_q      <= res_n;
      tx_data_q  <= tx_data_n;
      tx_valid_q <= tx_valid_n;
      overrun_q  <= overrun_n;
`ifdef INTERBYTE_TIMEOUT_EN
      to_q       <= to_n;
`endif
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign add_a_o     = a_q;
  assign add_b_o     = b_q;
  assign add_cin_o   = 1'b0;
  assign busy_o      = (state_q == ADD) || (state_q == TX_SUM) ||
                       (state_q == TX_CARRY);
  assign overrun_o   = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_adder_ctrl
//
// Directed bench for uart_adder_ctrl. A behavioural 64-bit adder closes the
// loop on add_a_o/add_b_o. The expected tx bytes are written out by hand
// for each vector. They are queued in exp_q and popped on every observed
// tx transfer. Build with INTERBYTE_TIMEOUT_EN to exercise the timeout
// path; the DUT uses TIMEOUT_CYCLES=50 in both builds.
// ---------------------------------------------------------------------------
module tb_uart_adder_ctrl;

  localparam int ADD_LATENCY = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [63:0] add_a_o;
  logic [63:0] add_b_o;
  logic        add_cin_o;
  logic [63:0] add_s_i;
  logic        add_cout_i;
  logic        busy_o;
  logic        overrun_o;
  logic [2:0]  dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  uart_adder_ctrl #(
    .OP_BYTES(8),
    .ADD_LATENCY(ADD_LATENCY),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .add_a_o(add_a_o),
    .add_b_o(add_b_o),
    .add_cin_o(add_cin_o),
    .add_s_i(add_s_i),
    .add_cout_i(add_cout_i),
    .busy_o(busy_o),
    .overrun_o(overrun_o),
    .dbg_state_o(dbg_state_o)
  );

  // Behavioural ripple-carry adder stand-in.
  assign {add_cout_i, add_s_i} = {1'b0, add_a_o} + {1'b0, add_b_o} + {64'd0, add_cin_o};

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] d);
    @(posedge clk_i); #1;
    rx_data_i  = d;
    rx_valid_i = 1'b1;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] v, input int from, input int upto);
    for (int i = from; i <= upto; i++) send_byte(v[i*8 +: 8]);
  endtask

  task automatic send_frame(input logic [63:0] a, input logic [63:0] b);
    send_bytes(a, 0, 7);
    send_bytes(b, 0, 7);
  endtask

  // Hand-computed response: sum bytes LSB first, then the carry byte.
  task automatic push_exp(input logic [63:0] sum, input logic carry);
    for (int i = 0; i < 8; i++) exp_q.push_back(sum[i*8 +: 8]);
    exp_q.push_back({7'b0, carry});
  endtask

  // Runs cycle by cycle right after the last operand byte has been accepted.
  // It drives tx_ready_i (always 1, or alternating) and an optional rx strobe
  // at cycle inject_at. Outputs are sampled on the falling edge, and each
  // transfer is scored against exp_q.
  task automatic collect(input int n_bytes, input bit toggle, input int inject_at,
                         output int first_valid, output int valid_cycles,
                         output int ovr_pulses);
    int cyc;
    int got;
    bit hold_pend;
    logic [7:0] hold_d;
    logic [7:0] e;
    cyc = 0; got = 0; hold_pend = 0; hold_d = '0;
    first_valid = -1; valid_cycles = 0; ovr_pulses = 0;
    while (got < n_bytes && cyc < 400) begin
      @(posedge clk_i); #1;
      cyc++;
      tx_ready_i = toggle ? ((cyc % 2) == 1) : 1'b1;
      rx_valid_i = (cyc == inject_at);
      rx_data_i  = 8'hA5;
      @(negedge clk_i);
      if (overrun_o) ovr_pulses++;
      if (cyc == 1) check("busy_in_add", {63'd0, busy_o}, 64'd1);
      if (hold_pend) begin
        check("tx_hold_data", {56'd0, tx_data_o}, {56'd0, hold_d});
        check("tx_hold_valid", {63'd0, tx_valid_o}, 64'd1);
        hold_pend = 0;
      end
      if (tx_valid_o) begin
        if (first_valid < 0) first_valid = cyc;
        valid_cycles++;
        if (tx_ready_i) begin
          if (exp_q.size() == 0) begin
            check("exp_q_nonempty", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("tx_byte%0d", got), {56'd0, tx_data_o}, {56'd0, e});
          end
          got++;
        end else begin
          hold_pend = 1;
          hold_d    = tx_data_o;
        end
      end
    end
    rx_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    if (got < n_bytes) check("tx_wait_budget", 64'(got), 64'(n_bytes));
  endtask

  // After the last transfer edge, the controller must be idle in RX_A.
  task automatic post_frame(input string tag);
    @(posedge clk_i); #1;
    check({tag, "_valid_low"}, {63'd0, tx_valid_o}, 64'd0);
    check({tag, "_busy_low"}, {63'd0, busy_o}, 64'd0);
    check({tag, "_state_rx_a"}, {61'd0, dbg_state_o}, 64'd0);
    check({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic idle_watch(input int n, output int ovr);
    ovr = 0;
    repeat (n) begin
      @(negedge clk_i);
      if (overrun_o) ovr++;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int fv, vc, ov;
    rst_i = 1'b1; rx_data_i = '0; rx_valid_i = 1'b0; tx_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_tx_valid", {63'd0, tx_valid_o}, 64'd0);
    check("rst_tx_data", {56'd0, tx_data_o}, 64'd0);
    check("rst_add_a", add_a_o, 64'd0);
    check("rst_add_b", add_b_o, 64'd0);
    check("rst_cin", {63'd0, add_cin_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_overrun", {63'd0, overrun_o}, 64'd0);
    check("rst_state", {61'd0, dbg_state_o}, 64'd0);

    // 20 + 20 = 40 = 0x28, streaming with ready held high
    push_exp(64'h0000_0000_0000_0028, 1'b0);
    send_frame(64'd20, 64'd20);
    collect(9, 1'b0, -1, fv, vc, ov);
    check("t1_latency", 64'(fv), 64'(ADD_LATENCY));
    check("t1_valid_cycles", 64'(vc), 64'd9);
    check("t1_no_overrun", 64'(ov), 64'd0);
    check("t1_operand_a", add_a_o, 64'd20);
    check("t1_operand_b", add_b_o, 64'd20);
    post_frame("t1");

    // all-ones + 1 wraps to zero with the carry set
    push_exp(64'h0000_0000_0000_0000, 1'b1);
    send_frame(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    collect(9, 1'b0, -1, fv, vc, ov);
    check("t2_latency", 64'(fv), 64'(ADD_LATENCY));
    post_frame("t2");

    // 9999 + 1 = 10000 = 0x2710 with ready toggling every cycle
    push_exp(64'h0000_0000_0000_2710, 1'b0);
    send_frame(64'd9999, 64'd1);
    collect(9, 1'b1, -1, fv, vc, ov);
    check("t3_no_overrun", 64'(ov), 64'd0);
    post_frame("t3");

    // rx strobe while in TX_SUM: dropped, overrun pulses once, stream intact
    push_exp(64'h0000_0000_0000_000F, 1'b0);
    send_frame(64'd7, 64'd8);
    collect(9, 1'b0, ADD_LATENCY + 2, fv, vc, ov);
    check("t4_overrun_pulses", 64'(ov), 64'd1);
    check("t4_operand_a_kept", add_a_o, 64'd7);
    check("t4_operand_b_kept", add_b_o, 64'd8);
    post_frame("t4");
    // next frame: 0x1234 + 0x1111 = 0x2345
    push_exp(64'h0000_0000_0000_2345, 1'b0);
    send_frame(64'h1234, 64'h1111);
    collect(9, 1'b0, -1, fv, vc, ov);
    post_frame("t4b");

    // reset after 3 sum bytes; 0x0102030405060708 + 0x1010101010101010
    exp_q.push_back(8'h18); exp_q.push_back(8'h17); exp_q.push_back(8'h16);
    send_frame(64'h0102_0304_0506_0708, 64'h1010_1010_1010_1010);
    collect(3, 1'b0, -1, fv, vc, ov);
    @(posedge clk_i); #1 rst_i = 1'b1;
    @(posedge clk_i); #1 rst_i = 1'b0;
    check("t5_valid_low", {63'd0, tx_valid_o}, 64'd0);
    check("t5_tx_data_zero", {56'd0, tx_data_o}, 64'd0);
    check("t5_add_a_zero", add_a_o, 64'd0);
    check("t5_add_b_zero", add_b_o, 64'd0);
    check("t5_busy_low", {63'd0, busy_o}, 64'd0);
    check("t5_state_rx_a", {61'd0, dbg_state_o}, 64'd0);
    push_exp(64'h0000_0000_0000_0002, 1'b0);
    send_frame(64'd1, 64'd1);
    collect(9, 1'b0, -1, fv, vc, ov);
    post_frame("t5");

    // partial frame of A = 1000 (0xE8 0x03 0x00), then 60 idle cycles
    send_bytes(64'd1000, 0, 2);
    idle_watch(60, ov);
`ifdef INTERBYTE_TIMEOUT_EN
    check("t6_timeout_pulse", 64'(ov), 64'd1);
    check("t6_state_rx_a", {61'd0, dbg_state_o}, 64'd0);
    check("t6_a_cleared", add_a_o, 64'd0);
    push_exp(64'h0000_0000_0000_07D0, 1'b0);
    send_frame(64'd1000, 64'd1000);
`else
    check("t6_no_timeout", 64'(ov), 64'd0);
    check("t6_still_rx_a", {61'd0, dbg_state_o}, 64'd0);
    check("t6_partial_a", add_a_o, 64'h0000_0000_0000_03E8);
    push_exp(64'h0000_0000_0000_07D0, 1'b0);
    send_bytes(64'd1000, 3, 7);
    send_bytes(64'd1000, 0, 7);
`endif
    collect(9, 1'b0, -1, fv, vc, ov);
    post_frame("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case a wait above ever escapes its own bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

endmodule
